nrisc_ula_wb_buffer: RTL

//  Execute->writeback stage directly downstream of NRISC_ULA. Captures ULA_OUT/ULA_flags plus destination

---
 rtl/nrisc_pkg.sv | 29 ++
 rtl/nrisc_ula_wb_buffer_if.sv | 43 ++++
 rtl/nrisc_fifo_ctrl.sv | 70 +++++++
 rtl/nrisc_ula_wb_buffer.sv | 82 ++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: datapath defaults, ULA flag layout and ULA_ctrl opcodes.
package nrisc_pkg;

  localparam int unsigned TamDefault     = 16;
  localparam int unsigned RegBitsDefault = 4;
  localparam int unsigned FlagW          = 3;

  // Bit positions inside the 3-bit ULA_flags word.
  localparam int unsigned FlagCarry = 0;
  localparam int unsigned FlagZero  = 1;
  localparam int unsigned FlagNeg   = 2;

  typedef enum logic [2:0] {
    UlaAdd,
    UlaSub,
    UlaAnd,
    UlaOr,
    UlaXor,
    UlaNot,
    UlaShl,
    UlaShr
  } ula_ctrl_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nrisc_ula_wb_buffer_if.sv
// ULA -> writeback buffer bus: producer side, register-file side, flags and forwarding.
interface nrisc_ula_wb_buffer_if
  import nrisc_pkg::*;
#(
  parameter int unsigned TAM      = TamDefault,
  parameter int unsigned REG_BITS = RegBitsDefault,
  parameter int unsigned DEPTH    = 2
);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic                in_valid;
  logic                in_ready;
  logic [TAM-1:0]      in_data;
  logic [FlagW-1:0]    in_flags;
  logic                in_flag_we;
  logic [REG_BITS-1:0] in_rd;
  logic                in_rd_we;

  logic                out_valid;
  logic                out_ready;
  logic [TAM-1:0]      out_data;
  logic [REG_BITS-1:0] out_rd;
  logic                out_rd_we;

  logic [FlagW-1:0]    flags_q;
  logic                fwd_valid;
  logic [REG_BITS-1:0] fwd_rd;
  logic [TAM-1:0]      fwd_data;
  logic [CntW-1:0]     count;

  modport slave (
    input  in_valid, in_data, in_flags, in_flag_we, in_rd, in_rd_we, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_rd_we,
    output flags_q, fwd_valid, fwd_rd, fwd_data, count
  );

  modport master (
    output in_valid, in_data, in_flags, in_flag_we, in_rd, in_rd_we, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_rd_we,
    input  flags_q, fwd_valid, fwd_rd, fwd_data, count
  );

endinterface

// File: rtl/nrisc_fifo_ctrl.sv
// In-order buffer bookkeeping: read/write pointers, occupancy, full/empty and flush.
module nrisc_fifo_ctrl
  import nrisc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_req_i,
  input  logic            pop_req_i,
  output logic            push_o,
  output logic            pop_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Full/empty come from registered state only, so in_ready never sees out_ready.
  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_o  = push_req_i & ~full_o & ~flush_i;
  assign pop_o   = pop_req_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_o) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_o)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_o, pop_o})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/nrisc_ula_wb_buffer.sv
// Execute->writeback buffer behind NRISC_ULA: in-order result storage, flag commit and
// forwarding of the youngest pending result.
module nrisc_ula_wb_buffer
  import nrisc_pkg::*;
#(
  parameter int unsigned TAM      = TamDefault,
  parameter int unsigned REG_BITS = RegBitsDefault,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  nrisc_ula_wb_buffer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic            push, pop, full, empty;
  logic [PtrW-1:0] wr_ptr, rd_ptr, young_ptr;
  logic [CntW-1:0] count;

  nrisc_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_fifo_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_req_i (bus.in_valid),
    .pop_req_i  (bus.out_ready),
    .push_o     (push),
    .pop_o      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count)
  );

  // Entry storage is intentionally left unreset; occupancy alone defines validity.
  logic [TAM-1:0]      data_q    [DEPTH];
  logic [REG_BITS-1:0] rd_q      [DEPTH];
  logic                rd_we_q   [DEPTH];
  logic [FlagW-1:0]    flags_mem_q [DEPTH];
  logic                flag_we_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr]      <= bus.in_data;
      rd_q[wr_ptr]        <= bus.in_rd;
      rd_we_q[wr_ptr]     <= bus.in_rd_we;
      flags_mem_q[wr_ptr] <= bus.in_flags;
      flag_we_q[wr_ptr]   <= bus.in_flag_we;
    end
  end

  logic [FlagW-1:0] arch_flags_q, arch_flags_d;

  always_comb begin
    arch_flags_d = arch_flags_q;
    if (pop && flag_we_q[rd_ptr]) arch_flags_d = flags_mem_q[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) arch_flags_q <= '0;
    else      arch_flags_q <= arch_flags_d;
  end

  assign young_ptr = wr_ptr - PtrW'(1);

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = data_q[rd_ptr];
  assign bus.out_rd    = rd_q[rd_ptr];
  assign bus.out_rd_we = rd_we_q[rd_ptr];
  assign bus.flags_q   = arch_flags_q;
  assign bus.fwd_valid = ~empty & rd_we_q[young_ptr];
  assign bus.fwd_rd    = rd_q[young_ptr];
  assign bus.fwd_data  = data_q[young_ptr];
  assign bus.count     = count;

endmodule
